// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter
//
// Arbitrates the single unified main-memory request port between the I-cache
// miss path, the D-cache miss path and D-side write-through stores.
// Miss grants sequence an 8-word block fill from the pipelined memory. Returning
// words are steered into the data array of the cache that owns the fill.
//
// Ports
//   clk, rst_n                  system clock; synchronous active-low reset
//   i_miss, i_addr              I-side read miss (held until i_done), byte address
//   d_miss, d_addr              D-side read miss (held until d_done), byte address
//   d_wr, d_wr_data             write-through store (held until d_wr_ack), data
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                   memory request port (one request per cycle)
//   mem_rdata, mem_rvalid       memory read return, in issue order
//   fill_sel, fill_we,
//   fill_idx, fill_data         data-array write: 0 = I-cache, 1 = D-cache
//   i_done, d_done              one-cycle block-complete pulses
//   d_wr_ack                    one-cycle pulse when the store is issued
//   busy                        high whenever the arbiter is not idle
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; grant d_wr > d_miss > i_miss
// WRITE | single store beat on the memory port, d_wr_ack pulses
// FILL  | issuing block reads base+2k, k = 0..7; early returns accepted
// DRAIN | all reads issued, waiting for the remaining returns
// DONE  | block complete, done pulse to the owning cache

module cache_fill_arbiter #(
    parameter int MEM_LAT   = 4,
    parameter int BLK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_miss,
    input  logic [15:0] i_addr,
    input  logic        d_miss,
    input  logic [15:0] d_addr,
    input  logic        d_wr,
    input  logic [15:0] d_wr_data,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        fill_sel,
    output logic        fill_we,
    output logic [2:0]  fill_idx,
    output logic [15:0] fill_data,
    output logic        i_done,
    output logic        d_done,
    output logic        d_wr_ack,
    output logic        busy
);

    localparam logic [2:0] LAST_IDX = 3'(BLK_WORDS - 1);

    // The 3-bit counters and the 4-bit block offset mask assume 8-word blocks.
    if (MEM_LAT < 1 || BLK_WORDS != 8) begin : g_bad_params
        $error("cache_fill_arbiter: unsupported MEM_LAT/BLK_WORDS combination");
    end

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        FILL,
        DRAIN,
        DONE
    } state_t;

    state_t      state;
    logic        owner;
    logic [15:0] base;
    logic [2:0]  k;
    logic [2:0]  r;

    logic [15:0] grant_base;
    logic [2:0]  k_next;
    logic        accepting;

    assign grant_base = (d_miss ? d_addr : i_addr) & 16'hFFF0;
    assign k_next     = k + 3'd1;
    assign accepting  = (state == FILL) || (state == DRAIN);

    // Returns go straight through to the data array; anything arriving outside
    // an active fill (e.g. stragglers after a reset abort) is dropped.
    assign fill_we   = mem_rvalid && accepting;
    assign fill_idx  = r;
    assign fill_sel  = owner;
    assign fill_data = fill_we ? mem_rdata : 16'h0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            base      <= 16'h0000;
            k         <= 3'd0;
            r         <= 3'd0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            d_wr_ack  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Request port and pulses default to quiet; each state re-asserts
            // what it needs for the coming cycle.
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            d_wr_ack  <= 1'b0;

            case (state)
                IDLE: begin
                    if (d_wr) begin
                        state     <= WRITE;
                        mem_en    <= 1'b1;
                        mem_wr    <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wr_data;
                        d_wr_ack  <= 1'b1;
                        busy      <= 1'b1;
                    end else if (d_miss || i_miss) begin
                        state    <= FILL;
                        owner    <= d_miss;
                        base     <= grant_base;
                        k        <= 3'd0;
                        r        <= 3'd0;
                        mem_en   <= 1'b1;
                        mem_addr <= grant_base;
                        busy     <= 1'b1;
                    end
                end

                WRITE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                FILL, DRAIN: begin
                    if (state == FILL) begin
                        if (k == LAST_IDX) begin
                            state <= DRAIN;
                        end else begin
                            k        <= k_next;
                            mem_en   <= 1'b1;
                            mem_addr <= base + {12'h000, k_next, 1'b0};
                        end
                    end
                    // Placed after the issue logic so a last return that lands
                    // during FILL overrides the next issue and ends the block.
                    if (mem_rvalid) begin
                        if (r == LAST_IDX) begin
                            state    <= DONE;
                            mem_en   <= 1'b0;
                            mem_addr <= 16'h0000;
                            i_done   <= ~owner;
                            d_done   <= owner;
                        end else begin
                            r <= r + 3'd1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
module tb_cache_fill_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_miss;
    logic [15:0] i_addr;
    logic        d_miss;
    logic [15:0] d_addr;
    logic        d_wr;
    logic [15:0] d_wr_data;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        fill_sel;
    logic        fill_we;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        i_done;
    logic        d_done;
    logic        d_wr_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    cache_fill_arbiter #(.MEM_LAT(4), .BLK_WORDS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_addr(i_addr),
        .d_miss(d_miss), .d_addr(d_addr),
        .d_wr(d_wr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .fill_sel(fill_sel), .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
        .i_done(i_done), .d_done(d_done), .d_wr_ack(d_wr_ack), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read accepted in cycle c returns in cycle c+4, word = addr ^ A5A5.
    // It is independent of the arbiter reset, so aborted fills still return data.
    logic        pv [5];
    logic [15:0] pa [5];
    logic        inj_rv;

    assign mem_rvalid = pv[4] | inj_rv;
    assign mem_rdata  = pv[4] ? (pa[4] ^ 16'hA5A5) : (inj_rv ? 16'h5A5A : 16'h0000);

    initial begin
        for (int i = 0; i < 5; i++) begin
            pv[i] = 1'b0;
            pa[i] = 16'h0000;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 4; i > 0; i--) begin
                pv[i] = pv[i-1];
                pa[i] = pa[i-1];
            end
            pv[0] = mem_en && !mem_wr;
            pa[0] = mem_addr;
        end
    end

    typedef struct packed {
        logic        rst;
        logic        i_miss;
        logic [15:0] i_addr;
        logic        d_miss;
        logic [15:0] d_addr;
        logic        d_wr;
        logic [15:0] d_wr_data;
        logic        inj_rv;
        logic        e_busy;
        logic        e_mem_en;
        logic        e_mem_wr;
        logic [15:0] e_mem_addr;
        logic [15:0] e_mem_wdata;
        logic        e_fill_we;
        logic        e_fill_sel;
        logic [2:0]  e_fill_idx;
        logic [15:0] e_fill_data;
        logic        e_i_done;
        logic        e_d_done;
        logic        e_d_wr_ack;
    } vec_t;

    function automatic vec_t blank();
        vec_t v;
        v = '0;
        return v;
    endfunction

    // Expected outputs in cycle T+j of a fill whose request was seen in IDLE at T.
    function automatic vec_t add_fill(vec_t vin, int j, logic [15:0] b, logic s);
        vec_t v;
        v = vin;
        if (j >= 1 && j <= 13) v.e_busy = 1'b1;
        if (j >= 1 && j <= 8) begin
            v.e_mem_en   = 1'b1;
            v.e_mem_addr = b + 16'(2 * (j - 1));
        end
        if (j >= 5 && j <= 12) begin
            v.e_fill_we   = 1'b1;
            v.e_fill_idx  = 3'(j - 5);
            v.e_fill_sel  = s;
            v.e_fill_data = (b + 16'(2 * (j - 5))) ^ 16'hA5A5;
        end
        if (j == 13) begin
            if (s) v.e_d_done = 1'b1;
            else   v.e_i_done = 1'b1;
        end
        return v;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, ".busy"},      16'(busy),      16'h0);
        chk({nm, ".mem_en"},    16'(mem_en),    16'h0);
        chk({nm, ".mem_wr"},    16'(mem_wr),    16'h0);
        chk({nm, ".mem_addr"},  mem_addr,       16'h0);
        chk({nm, ".mem_wdata"}, mem_wdata,      16'h0);
        chk({nm, ".fill_we"},   16'(fill_we),   16'h0);
        chk({nm, ".fill_sel"},  16'(fill_sel),  16'h0);
        chk({nm, ".fill_idx"},  16'(fill_idx),  16'h0);
        chk({nm, ".fill_data"}, fill_data,      16'h0);
        chk({nm, ".i_done"},    16'(i_done),    16'h0);
        chk({nm, ".d_done"},    16'(d_done),    16'h0);
        chk({nm, ".d_wr_ack"},  16'(d_wr_ack),  16'h0);
    endtask

    // One cycle: drive inputs just after the rising edge, compare on the falling edge.
    task automatic run_row(vec_t v, string nm);
        @(posedge clk);
        #1;
        rst_n     = !v.rst;
        i_miss    = v.i_miss;
        i_addr    = v.i_addr;
        d_miss    = v.d_miss;
        d_addr    = v.d_addr;
        d_wr      = v.d_wr;
        d_wr_data = v.d_wr_data;
        inj_rv    = v.inj_rv;
        @(negedge clk);
        chk({nm, ".busy"},    16'(busy),    16'(v.e_busy));
        chk({nm, ".mem_en"},  16'(mem_en),  16'(v.e_mem_en));
        chk({nm, ".mem_wr"},  16'(mem_wr),  16'(v.e_mem_wr));
        if (v.e_mem_en) chk({nm, ".mem_addr"}, mem_addr, v.e_mem_addr);
        if (v.e_mem_wr) chk({nm, ".mem_wdata"}, mem_wdata, v.e_mem_wdata);
        chk({nm, ".fill_we"}, 16'(fill_we), 16'(v.e_fill_we));
        if (v.e_fill_we) begin
            chk({nm, ".fill_idx"},  16'(fill_idx), 16'(v.e_fill_idx));
            chk({nm, ".fill_sel"},  16'(fill_sel), 16'(v.e_fill_sel));
            chk({nm, ".fill_data"}, fill_data,     v.e_fill_data);
        end
        chk({nm, ".i_done"},   16'(i_done),   16'(v.e_i_done));
        chk({nm, ".d_done"},   16'(d_done),   16'(v.e_d_done));
        chk({nm, ".d_wr_ack"}, 16'(d_wr_ack), 16'(v.e_d_wr_ack));
    endtask

    vec_t tbl [64];

    initial begin
        vec_t v;

        // I miss at 0x0126 seen at row 0
        for (int n = 0; n <= 13; n++) begin
            tbl[n] = blank();
            tbl[n].i_miss = 1'b1;
            tbl[n].i_addr = 16'h0126;
            tbl[n] = add_fill(tbl[n], n, 16'h0120, 1'b0);
        end
        tbl[14] = blank();
        tbl[15] = blank();
        // I and D miss together at row 16: D block first, then I block
        for (int n = 16; n <= 29; n++) begin
            tbl[n] = blank();
            tbl[n].i_miss = 1'b1;
            tbl[n].i_addr = 16'h1234;
            tbl[n].d_miss = 1'b1;
            tbl[n].d_addr = 16'h4008;
            tbl[n] = add_fill(tbl[n], n - 16, 16'h4000, 1'b1);
        end
        for (int n = 30; n <= 43; n++) begin
            tbl[n] = blank();
            tbl[n].i_miss = 1'b1;
            tbl[n].i_addr = 16'h1234;
            tbl[n] = add_fill(tbl[n], n - 30, 16'h1230, 1'b0);
        end
        tbl[44] = blank();
        // Store and D miss together at row 45: store first, then the fill
        for (int n = 45; n <= 46; n++) begin
            tbl[n] = blank();
            tbl[n].d_wr      = 1'b1;
            tbl[n].d_wr_data = 16'hBEEF;
            tbl[n].d_miss    = 1'b1;
            tbl[n].d_addr    = 16'h2002;
        end
        tbl[46].e_busy      = 1'b1;
        tbl[46].e_mem_en    = 1'b1;
        tbl[46].e_mem_wr    = 1'b1;
        tbl[46].e_mem_addr  = 16'h2002;
        tbl[46].e_mem_wdata = 16'hBEEF;
        tbl[46].e_d_wr_ack  = 1'b1;
        for (int n = 47; n <= 60; n++) begin
            tbl[n] = blank();
            tbl[n].d_miss = 1'b1;
            tbl[n].d_addr = 16'h2002;
            tbl[n] = add_fill(tbl[n], n - 47, 16'h2000, 1'b1);
        end
        tbl[61] = blank();
        // Spurious return while idle
        tbl[62] = blank();
        tbl[62].inj_rv = 1'b1;
        tbl[63] = blank();

        rst_n     = 1'b0;
        i_miss    = 1'b0;
        i_addr    = 16'h0000;
        d_miss    = 1'b0;
        d_addr    = 16'h0000;
        d_wr      = 1'b0;
        d_wr_data = 16'h0000;
        inj_rv    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");

        for (int n = 0; n < 64; n++) run_row(tbl[n], $sformatf("tbl%0d", n));

        // D miss arrives mid I fill: I fill completes, D fill follows
        for (int j = 0; j <= 27; j++) begin
            v = blank();
            v.i_miss = (j <= 13);
            v.i_addr = 16'h0300;
            v.d_miss = (j >= 6);
            v.d_addr = 16'h0510;
            if (j <= 13) v = add_fill(v, j, 16'h0300, 1'b0);
            else         v = add_fill(v, j - 14, 16'h0510, 1'b1);
            run_row(v, $sformatf("preempt%0d", j));
        end
        run_row(blank(), "preempt_end");

        // Reset for one edge at T+7 of a fill; stragglers must be ignored
        for (int j = 0; j <= 12; j++) begin
            v = blank();
            if (j <= 7) begin
                v.i_addr = 16'h0700;
                v = add_fill(v, j, 16'h0700, 1'b0);
            end
            v.i_miss = (j <= 6);
            v.rst    = (j == 7);
            v.inj_rv = (j == 12);
            run_row(v, $sformatf("rst%0d", j));
            if (j == 8) chk_all_zero("rst_after");
        end
        run_row(blank(), "rst_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Arbitrates between the I-cache miss path, the D-cache miss path and D-side write-through stores for the single unified main memory. Sequences 8-word block fills from the pipelined 4-cycle-latency memory. Steers returning words into the requesting cache's data array. Sits between the fetch/memory pipeline stages and main memory; it is the only block that drives the memory request port.

## Interface
Parameters:
- MEM_LAT, 4: cycles from accepted read request to mem_rvalid for that word.
- BLK_WORDS, 8: 16-bit words per cache block (16 bytes); fixed to 8 in this revision.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_miss  in  1  I-cache read miss; held high until i_done
- i_addr  in  16  I-side miss byte address
- d_miss  in  1  D-cache read miss; held high until d_done
- d_addr  in  16  D-side byte address (miss or store)
- d_wr  in  1  write-through store request; held until d_wr_ack
- d_wr_data  in  16  store data
- mem_en  out  1  memory request valid (one request accepted per cycle)
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  write data
- mem_rdata  in  16  read return data
- mem_rvalid  in  1  mem_rdata valid this cycle
- fill_sel  out  1  fill target: 0 = I-cache, 1 = D-cache
- fill_we  out  1  write fill_data into target data array
- fill_idx  out  3  word index within block
- fill_data  out  16  word to write (= mem_rdata)
- i_done  out  1  one-cycle pulse: I-side block complete
- d_done  out  1  one-cycle pulse: D-side block complete
- d_wr_ack  out  1  one-cycle pulse: store issued
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WRITE, FILL, DRAIN, DONE.
- IDLE grant, fixed priority: d_wr > d_miss > i_miss. Grant is latched: owner bit, block base (addr & 16'hFFF0) and store data are registered.
- Transitions:
  - IDLE -> WRITE on d_wr.
  - IDLE -> FILL on d_miss or i_miss.
  - WRITE -> IDLE after 1 cycle.
  - FILL -> DRAIN after 8 issues.
  - DRAIN -> DONE after 8th return.
  - DONE -> IDLE after 1 cycle.
- WRITE: mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wr_data, d_wr_ack=1.
- FILL: issue counter k=0..7; mem_en=1, mem_wr=0, mem_addr=base+2k, one per cycle. Returns are accepted during FILL as well; the first return overlaps issue k=4.
- Return counter r=0..7 advances on each mem_rvalid in FILL/DRAIN. fill_we=mem_rvalid, fill_idx=r, fill_data=mem_rdata, fill_sel=owner. Returns are in issue order.
- If the 8th return (r=7) arrives while still in FILL, go directly to DONE.
- DONE: pulse i_done or d_done per owner. The cache sets valid/tag on this edge, so the miss drops before the next IDLE sample.
- No preemption: a granted fill completes even if its miss deasserts or a higher-priority request appears. Waiting requests are served in the IDLE cycle after DONE.
- mem_rvalid in IDLE/WRITE/DONE is ignored: no fill_we, counters unchanged.
- Counters are 3-bit. The return counter never wraps within a fill and is cleared on entry to FILL.

## Timing
- Reset (rst_n=0 at an edge) leaves state=IDLE, k=r=0, owner=0. All outputs are 0: mem_en, mem_wr, mem_addr, mem_wdata, fill_*, dones, d_wr_ack, busy.
- Reset mid-fill aborts the fill with no done pulse. Late mem_rvalid after reset is ignored.
- Outputs are decoded from registered state/counters. fill_we/fill_data are combinational from mem_rvalid/mem_rdata, gated by state.
- Miss first seen in IDLE at cycle T:
  - issues at T+1..T+8
  - returns at T+1+MEM_LAT..T+8+MEM_LAT (T+5..T+12)
  - DONE/done pulse at T+13
  - IDLE at T+14
- Store seen at T: WRITE and d_wr_ack at T+1, IDLE at T+2.
- Back-to-back: a request pending while in DONE is granted in the IDLE cycle at T+14. There are no dead cycles beyond the single IDLE cycle.
- busy is high from T+1 through the DONE/WRITE cycle inclusive.

## Test plan
- I-miss only, i_addr=16'h0126, memory word at A = A ^ 16'hA5A5.
  - mem_addr 0x0120..0x012E at T+1..T+8.
  - fill_we with fill_idx 0..7, fill_sel=0, data matching, at T+5..T+12.
  - i_done pulse at T+13, d_done never.
- i_miss and d_miss both rise at T with d_addr=16'h4008.
  - D fill of 0x4000 block first, d_done at T+13.
  - I fill issues start T+15, i_done at T+27.
- d_wr with d_addr=16'h2002 and d_wr_data=16'hBEEF arrives in the same cycle as d_miss.
  - mem_en=mem_wr=1, mem_addr=0x2002, mem_wdata=0xBEEF, d_wr_ack at T+1.
  - D fill grant at T+2.
- d_miss raised at T+6 while an I fill is active.
  - The I fill completes untouched.
  - D issues begin the cycle after IDLE following i_done.
- rst_n=0 for one edge at T+7 of a fill.
  - All outputs 0 next cycle, no done pulse.
  - Stray mem_rvalid at T+8..T+12 produces no fill_we.
- Spurious mem_rvalid in IDLE with no requests: fill_we=0, busy=0, state stays IDLE.
